stall_ctrl: RTL and testbench
=============================

STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32, giving the number of divider busy cycles (range 2..63).
REQ-002 SHALL have parameter CNT_W, default 6, giving the busy-counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports rs_d, rt_d, input, 5 each, the source registers of the instruction in Decode.
REQ-006 SHALL have port rt_e, input, 5, the destination register of the instruction in Execute.
REQ-007 SHALL have ports memtoreg_e, regwrite_e, input, 1 each, the load/write flags of the instruction in Execute.
REQ-008 SHALL have ports branch_taken_d, jump_d, input, 1 each, the Decode redirect requests.
REQ-009 SHALL have port div_e, input, 1, high while a divide instruction occupies Execute.
REQ-010 SHALL have port exception_m, input, 1, an exception raised in Memory.
REQ-011 SHALL have ports stall_f, stall_d, stall_e, output, 1 each, holding the PC, F/D and D/E pipeline registers.
REQ-012 SHALL have ports flush_d, flush_e, flush_m, output, 1 each, clearing the F/D, D/E and E/M pipeline registers.
REQ-013 SHALL have ports div_go, div_busy, div_done, output, 1 each, for divider start pulse, busy level and completion pulse.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE plus a CNT_W-bit down-counter.
REQ-015 IDLE->RUN when div_e=1 and exception_m=0; div_go=1 for exactly that cycle; counter loads DIV_CYCLES-1.
REQ-016 RUN: counter decrements each cycle; at counter==0 go to DONE.
REQ-017 RUN: stall_f=stall_d=stall_e=1, flush_m=1 (bubble into Memory), div_busy=1.
REQ-018 DONE: div_done=1 for one cycle; stalls released; then IDLE unconditionally, even if div_e is still 1.
REQ-019 The total stall from div_go to div_done SHALL be exactly DIV_CYCLES cycles.
REQ-020 Load-use hazard = memtoreg_e & regwrite_e & (rt_e!=0) & ((rt_e==rs_d)|(rt_e==rt_d)); it SHALL force stall_f=stall_d=1 and flush_e=1.
REQ-021 branch_taken_d|jump_d SHALL assert flush_d, unless stall_d is 1 in the same cycle.
REQ-022 exception_m SHALL assert flush_d, flush_e and flush_m and deassert all stalls.
REQ-023 exception_m in RUN SHALL abort to IDLE at the next edge, with no div_done.
REQ-024 Priority SHALL be exception_m > divider RUN > load-use > branch/jump.
REQ-025 Load-use detection SHALL be suppressed while in RUN, because the divider stall already covers it.
REQ-026 All outputs except the FSM state SHALL be combinational from the current state and inputs, with zero latency.

Reset
REQ-027 Assertion SHALL immediately force state=IDLE and counter=0, independent of clk.
REQ-028 While reset=1, all outputs SHALL be 0.
REQ-029 Reset in RUN SHALL abandon the divide; no div_done follows.
REQ-030 After release, the first div_go SHALL require a fresh div_e sample.

Structure
REQ-031 The state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the DIV_CYCLES default SHALL reside in the shared CPU package.
REQ-032 The FSM and counter SHALL form sub-module div_seq; hazard and priority logic SHALL stay in stall_ctrl.

Verification
REQ-033 rt_e=5, memtoreg_e=1, regwrite_e=1, rs_d=5 -> stall_f=stall_d=flush_e=1 in the same cycle; rt_e=0 -> no stall.
REQ-034 div_e=1 in IDLE -> div_go one cycle, stalls high 31 cycles, div_done on cycle 32, then IDLE with div_e still 1 and no restart.
REQ-035 exception_m=1 on RUN cycle 10 -> flush_d/e/m=1, stalls 0, IDLE next cycle, no div_done.
REQ-036 branch_taken_d=1 with a coincident load-use -> flush_d=0 and stall_d=1; branch_taken_d=1 alone -> flush_d=1.
REQ-037 reset pulsed mid-RUN between clock edges -> outputs 0 immediately, state IDLE, counter 0.
REQ-038 DIV_CYCLES=2 -> div_go, one RUN cycle, div_done on the next cycle.

Source files
------------

// File: rtl/stall_ctrl_pkg.sv
// Shared CPU pipeline-control definitions: divider sequencer states and defaults.
package stall_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_CYCLES_DEF = 32;
    localparam int CNT_W_DEF      = 6;

    // Asserted for a register-file read that depends on a load in Execute.
    function automatic logic load_use(input logic       memtoreg,
                                      input logic       regwrite,
                                      input logic [4:0] rt_ex,
                                      input logic [4:0] rs_dec,
                                      input logic [4:0] rt_dec);
        return memtoreg & regwrite & (rt_ex != 5'd0) &
               ((rt_ex == rs_dec) | (rt_ex == rt_dec));
    endfunction

endpackage

// File: rtl/div_seq.sv
// Multi-cycle divider sequencer: IDLE -> RUN (DIV_CYCLES-1 cycles) -> DONE -> IDLE.
module div_seq
    import stall_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output div_state_e       state,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The go cycle counts toward the total, so RUN lasts DIV_CYCLES-1 cycles
    // and leaves as the counter steps from 1 to 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = CNT_LOAD;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline hazard unit: load-use, redirect, exception flushes and divider stalls.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [4:0] rt_e,
    input  logic       memtoreg_e,
    input  logic       regwrite_e,
    input  logic       branch_taken_d,
    input  logic       jump_d,
    input  logic       div_e,
    input  logic       exception_m,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_e,
    output logic       flush_d,
    output logic       flush_e,
    output logic       flush_m,
    output logic       div_go,
    output logic       div_busy,
    output logic       div_done
);

    div_state_e       div_state;
    logic [CNT_W-1:0] div_cnt;
    logic             lu_haz;
    logic             redirect;
    logic             div_run;

    div_seq #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_seq (
        .clk   (clk),
        .reset (reset),
        .start (div_e & ~exception_m),
        .abort (exception_m),
        .state (div_state),
        .cnt   (div_cnt)
    );

    assign lu_haz   = load_use(memtoreg_e, regwrite_e, rt_e, rs_d, rt_d);
    assign redirect = branch_taken_d | jump_d;
    assign div_run  = (div_state == RUN);

    // Priority: exception, divider RUN, load-use, redirect. A stalled Decode
    // swallows the redirect; it is re-raised once the stall clears.
    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_m  = 1'b0;
        div_go   = 1'b0;
        div_busy = 1'b0;
        div_done = 1'b0;
        if (!reset) begin
            if (exception_m) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
                flush_m = 1'b1;
            end else if (div_run) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_m = 1'b1;
            end else if (lu_haz) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end else if (redirect) begin
                flush_d = 1'b1;
            end
            div_go   = (div_state == IDLE) & div_e & ~exception_m;
            div_busy = div_run;
            div_done = (div_state == DONE);
        end
    end

    logic unused_cnt;
    assign unused_cnt = ^div_cnt;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: hazards, divider timing, exception abort, reset.
module tb_stall_ctrl;
    import stall_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] rs_d = '0, rt_d = '0, rt_e = '0;
    logic       memtoreg_e = 0, regwrite_e = 0, branch_taken_d = 0, jump_d = 0;
    logic       div_e = 0, div_e2 = 0, exception_m = 0;

    logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, div_go, div_busy, div_done;
    logic stall_f2, stall_d2, stall_e2, flush_d2, flush_e2, flush_m2, div_go2, div_busy2, div_done2;
    logic [8:0] outs, outs2;

    assign outs  = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, div_go, div_busy, div_done};
    assign outs2 = {stall_f2, stall_d2, stall_e2, flush_d2, flush_e2, flush_m2, div_go2, div_busy2, div_done2};

    // {stall_f,stall_d,stall_e, flush_d,flush_e,flush_m, div_go,div_busy,div_done}
    localparam logic [8:0] O_NONE = 9'b000_000_000;
    localparam logic [8:0] O_GO   = 9'b000_000_100;
    localparam logic [8:0] O_RUN  = 9'b111_001_010;
    localparam logic [8:0] O_DONE = 9'b000_000_001;
    localparam logic [8:0] O_LU   = 9'b110_010_000;
    localparam logic [8:0] O_BR   = 9'b000_100_000;
    localparam logic [8:0] O_EXC  = 9'b000_111_000;

    stall_ctrl u_dut (
        .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d), .rt_e(rt_e),
        .memtoreg_e(memtoreg_e), .regwrite_e(regwrite_e),
        .branch_taken_d(branch_taken_d), .jump_d(jump_d),
        .div_e(div_e), .exception_m(exception_m),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
        .div_go(div_go), .div_busy(div_busy), .div_done(div_done)
    );

    stall_ctrl #(.DIV_CYCLES(2), .CNT_W(6)) u_dut2 (
        .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d), .rt_e(rt_e),
        .memtoreg_e(memtoreg_e), .regwrite_e(regwrite_e),
        .branch_taken_d(branch_taken_d), .jump_d(jump_d),
        .div_e(div_e2), .exception_m(exception_m),
        .stall_f(stall_f2), .stall_d(stall_d2), .stall_e(stall_e2),
        .flush_d(flush_d2), .flush_e(flush_e2), .flush_m(flush_m2),
        .div_go(div_go2), .div_busy(div_busy2), .div_done(div_done2)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic set_lu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rte,
                          input logic m, input logic w);
        rs_d = rs; rt_d = rt; rt_e = rte; memtoreg_e = m; regwrite_e = w;
    endtask

    initial begin
        logic seen_done;

        // reset holds every output low even with requests present
        div_e = 1; branch_taken_d = 1; div_e2 = 1;
        #3;
        chk("rst_outs", outs, O_NONE);
        chk("rst_outs2", outs2, O_NONE);
        chk("rst_state", 32'(u_dut.u_seq.state_q), 32'(IDLE));
        div_e = 0; branch_taken_d = 0; div_e2 = 0;
        tick;
        reset = 0;
        #1 chk("idle", outs, O_NONE);

        // load-use and redirect vectors
        set_lu(5'd5, 5'd1, 5'd5, 1, 1); #1 chk("lu_rs", outs, O_LU);
        set_lu(5'd3, 5'd5, 5'd5, 1, 1); #1 chk("lu_rt", outs, O_LU);
        set_lu(5'd0, 5'd0, 5'd0, 1, 1); #1 chk("lu_r0", outs, O_NONE);
        set_lu(5'd5, 5'd1, 5'd5, 0, 1); #1 chk("lu_nomem", outs, O_NONE);
        set_lu(5'd5, 5'd1, 5'd5, 1, 1); branch_taken_d = 1;
        #1 chk("br_lu", outs, O_LU);
        set_lu(5'd0, 5'd0, 5'd0, 0, 0);
        #1 chk("br_only", outs, O_BR);
        branch_taken_d = 0; jump_d = 1;
        #1 chk("jump", outs, O_BR);
        jump_d = 0; exception_m = 1;
        #1 chk("exc", outs, O_EXC);
        set_lu(5'd5, 5'd1, 5'd5, 1, 1); branch_taken_d = 1; div_e = 1;
        #1 chk("exc_prio", outs, O_EXC);
        set_lu(5'd0, 5'd0, 5'd0, 0, 0); branch_taken_d = 0; exception_m = 0;

        // full divide: go, 31 RUN cycles, DONE on cycle 32
        #1 chk("div_go", outs, O_GO);
        tick;
        for (int i = 1; i <= 31; i++) begin
            if (i == 5) set_lu(5'd5, 5'd1, 5'd5, 1, 1);
            if (i == 6) begin set_lu(5'd0, 5'd0, 5'd0, 0, 0); branch_taken_d = 1; end
            if (i == 7) branch_taken_d = 0;
            #1 chk($sformatf("run%0d", i), outs, O_RUN);
            tick;
        end
        #1 chk("done", outs, O_DONE);
        tick;
        chk("post_state", 32'(u_dut.u_seq.state_q), 32'(IDLE));
        chk("post_cnt", 32'(u_dut.u_seq.cnt_q), 0);
        div_e = 0;
        #1 chk("post_outs", outs, O_NONE);

        // exception on RUN cycle 10 aborts without div_done
        tick;
        div_e = 1;
        #1 chk("go2", outs, O_GO);
        tick;
        div_e = 0;
        for (int i = 1; i < 10; i++) tick;
        chk("run10_cnt", 32'(u_dut.u_seq.cnt_q), 22);
        exception_m = 1;
        #1 chk("exc_run", 32'(outs[8:3]), 32'(O_EXC[8:3]));
        tick;
        exception_m = 0;
        #1 chk("exc_state", 32'(u_dut.u_seq.state_q), 32'(IDLE));
        chk("exc_after", outs, O_NONE);
        tick; tick;
        #1 chk("exc_nodone", outs, O_NONE);

        // asynchronous reset mid-RUN
        tick;
        div_e = 1;
        #1;
        tick;
        div_e = 0;
        tick; tick;
        #1 reset = 1;
        #1 chk("arst_outs", outs, O_NONE);
        chk("arst_state", 32'(u_dut.u_seq.state_q), 32'(IDLE));
        chk("arst_cnt", 32'(u_dut.u_seq.cnt_q), 0);
        tick;
        reset = 0;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            #1 if (div_done || div_busy) seen_done = 1;
            tick;
        end
        chk("arst_nodone", 32'(seen_done), 0);

        // DIV_CYCLES=2: go, one RUN cycle, done
        div_e2 = 1;
        #1 chk("d2_go", outs2, O_GO);
        tick;
        div_e2 = 0;
        #1 chk("d2_run", outs2, O_RUN);
        tick;
        #1 chk("d2_done", outs2, O_DONE);
        tick;
        #1 chk("d2_idle", outs2, O_NONE);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
